regfile_bypass: RTL and testbench



---
 rtl/regfile_bypass_if.sv | 55 +++++
 rtl/regfile_bypass.sv | 78 +++++++
 tb/tb_regfile_bypass.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/regfile_bypass_if.sv
// ---------------------------------------------------------------------------
// regfile_bypass_if
//   Bundles the decode-stage read selects, the MEM/WB write-back triple and
//   the register-file outputs into one interface.
//
//   Signals:
//     read1RegSel [2:0]       register index for read port 1
//     read2RegSel [2:0]       register index for read port 2
//     writeRegSel [2:0]       register index for the write port (MEM/WB latch)
//     writeData   [WIDTH-1:0] write-back data
//     writeEn                 write enable
//     read1Data   [WIDTH-1:0] bypassed data for read port 1
//     read2Data   [WIDTH-1:0] bypassed data for read port 2
//     err                     X/Z seen on a control/select input (sim aid)
//
//   Modports:
//     master - the pipeline side that drives selects and write-back
//     slave  - the register file itself
// ---------------------------------------------------------------------------
interface regfile_bypass_if #(
  parameter int WIDTH = 16
);

  logic [2:0]       read1RegSel;
  logic [2:0]       read2RegSel;
  logic [2:0]       writeRegSel;
  logic [WIDTH-1:0] writeData;
  logic             writeEn;
  logic [WIDTH-1:0] read1Data;
  logic [WIDTH-1:0] read2Data;
  logic             err;

  modport master (
    output read1RegSel,
    output read2RegSel,
    output writeRegSel,
    output writeData,
    output writeEn,
    input  read1Data,
    input  read2Data,
    input  err
  );

  modport slave (
    input  read1RegSel,
    input  read2RegSel,
    input  writeRegSel,
    input  writeData,
    input  writeEn,
    output read1Data,
    output read2Data,
    output err
  );

endinterface

// File: rtl/regfile_bypass.sv
// ---------------------------------------------------------------------------
// regfile_bypass
//   Eight-entry register file for the decode stage with two combinational
//   read ports, one synchronous write port and write-to-read bypass, so a
//   value being written back this cycle is already visible to decode.
//
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - asynchronous active-high reset, clears every entry
//     bus  - regfile_bypass_if.slave: read selects, write-back triple,
//            bypassed read data and the X/Z error flag
//
//   R0 is an ordinary writable register (not hardwired to zero).
// ---------------------------------------------------------------------------
module regfile_bypass #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  regfile_bypass_if.slave  bus
);

  // The 3-bit specifiers fix the depth; this is deliberately not a parameter.
  localparam int NREGS = 8;

  logic [WIDTH-1:0] regFile_q [NREGS];
  logic [NREGS-1:0] writeOneHot;

  logic [WIDTH-1:0] stored1;
  logic [WIDTH-1:0] stored2;
  logic             bypass1;
  logic             bypass2;

  // One-hot write decode: exactly one entry enabled while writeEn is high,
  // none otherwise.
  always_comb begin
    writeOneHot = '0;
    if (bus.writeEn) begin
      writeOneHot[bus.writeRegSel] = 1'b1;
    end
  end

  // Each entry gets its own flop bank with a private load enable. Reset is
  // asynchronous and dominates any write presented in the same cycle.
  for (genvar g = 0; g < NREGS; g++) begin : gEntry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        regFile_q[g] <= '0;
      end else if (writeOneHot[g]) begin
        regFile_q[g] <= bus.writeData;
      end
    end
  end

  // Combinational read of the stored values. During reset the entries are
  // already cleared, so stored reads naturally return zero.
  always_comb begin
    stored1 = regFile_q[bus.read1RegSel];
    stored2 = regFile_q[bus.read2RegSel];
  end

  // Bypass is evaluated per port and gated by writeEn; it is intentionally
  // not gated by rst, so a write-back presented during reset is still seen
  // by decode even though it will not be stored.
  always_comb begin
    bypass1 = bus.writeEn && (bus.writeRegSel == bus.read1RegSel);
    bypass2 = bus.writeEn && (bus.writeRegSel == bus.read2RegSel);
  end

  assign bus.read1Data = bypass1 ? bus.writeData : stored1;
  assign bus.read2Data = bypass2 ? bus.writeData : stored2;

  // Simulation aid only: flags X/Z on any control or select input. Synthesis
  // tools evaluate $isunknown as constant 0.
  assign bus.err = $isunknown({bus.writeEn, bus.writeRegSel,
                               bus.read1RegSel, bus.read2RegSel});

endmodule

// File: tb/tb_regfile_bypass.sv
// ---------------------------------------------------------------------------
// tb_regfile_bypass
//   Self-checking bench for regfile_bypass: a table of directed vectors with
//   hand-computed expected outputs, plus hand-written sequences for reset
//   behaviour (async clear mid-cycle, writes blocked during reset, write on
//   the first edge after reset release).
// ---------------------------------------------------------------------------
module tb_regfile_bypass;

  typedef struct {
    logic        we;
    logic [2:0]  wsel;
    logic [15:0] wdata;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [15:0] exp1;
    logic [15:0] exp2;
  } vec_t;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  vec_t vecs[$];

  regfile_bypass_if #(.WIDTH(16)) bus ();

  regfile_bypass #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one set of inputs onto the interface.
  task automatic applyStimulus(input logic we, input logic [2:0] wsel,
                               input logic [15:0] wdata,
                               input logic [2:0] r1, input logic [2:0] r2);
    bus.writeEn     = we;
    bus.writeRegSel = wsel;
    bus.writeData   = wdata;
    bus.read1RegSel = r1;
    bus.read2RegSel = r2;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Check both read ports and the error flag at once.
  task automatic checkPorts(input string name, input logic [15:0] e1,
                            input logic [15:0] e2);
    checkOutput({name, ".r1"}, bus.read1Data, e1);
    checkOutput({name, ".r2"}, bus.read2Data, e2);
    checkOutput({name, ".err"}, {15'd0, bus.err}, 16'h0000);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Directed vectors: inputs are applied after a falling edge, outputs
    // checked before the following rising edge, which then commits writes.
    // Load R0..R7 with 16'h1000+i; bypass makes each value visible at once.
    vecs.push_back('{1'b1, 3'd0, 16'h1000, 3'd0, 3'd1, 16'h1000, 16'h0000});
    for (int i = 1; i < 8; i++) begin
      vecs.push_back('{1'b1, 3'(i), 16'(16'h1000 + i), 3'(i), 3'(i - 1),
                       16'(16'h1000 + i), 16'(16'h1000 + i - 1)});
    end
    // Read pairs (i, 7-i) from storage.
    for (int i = 0; i < 8; i++) begin
      vecs.push_back('{1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i),
                       16'(16'h1000 + i), 16'(16'h1007 - i)});
    end
    // R3 := 00AA, then gated bypass (writeEn=0 with matching select).
    vecs.push_back('{1'b1, 3'd3, 16'h00AA, 3'd3, 3'd3, 16'h00AA, 16'h00AA});
    vecs.push_back('{1'b0, 3'd3, 16'hBEEF, 3'd3, 3'd4, 16'h00AA, 16'h1004});
    vecs.push_back('{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'h00AA, 16'h00AA});
    // Bypass on port 1 only, then the stored result.
    vecs.push_back('{1'b1, 3'd3, 16'h5555, 3'd3, 3'd2, 16'h5555, 16'h1002});
    vecs.push_back('{1'b0, 3'd0, 16'h0000, 3'd3, 3'd2, 16'h5555, 16'h1002});
    // Same register on both ports with bypass.
    vecs.push_back('{1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, 16'h1234, 16'h1234});
    vecs.push_back('{1'b0, 3'd5, 16'h0000, 3'd5, 3'd5, 16'h1234, 16'h1234});
    // R0 is writable.
    vecs.push_back('{1'b1, 3'd0, 16'h8001, 3'd1, 3'd0, 16'h1001, 16'h8001});
    vecs.push_back('{1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 16'h8001, 16'h1007});
    // Back-to-back writes to R6: last one wins.
    vecs.push_back('{1'b1, 3'd6, 16'hAAAA, 3'd6, 3'd6, 16'hAAAA, 16'hAAAA});
    vecs.push_back('{1'b1, 3'd6, 16'hBBBB, 3'd6, 3'd0, 16'hBBBB, 16'h8001});
    vecs.push_back('{1'b0, 3'd0, 16'h0000, 3'd6, 3'd6, 16'hBBBB, 16'hBBBB});

    // Initial reset.
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Every entry reads zero after reset.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i));
      #1;
      checkPorts($sformatf("reset_rd%0d", i), 16'h0000, 16'h0000);
      @(negedge clk);
    end

    // Table-driven section.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].wsel, vecs[i].wdata,
                    vecs[i].r1, vecs[i].r2);
      #1;
      checkPorts($sformatf("vec%0d", i), vecs[i].exp1, vecs[i].exp2);
      @(negedge clk);
    end

    // Fill every entry with FFFF.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), 16'hFFFF, 3'd0, 3'd0);
      @(negedge clk);
    end
    applyStimulus(1'b0, 3'd0, 16'h0000, 3'd2, 3'd5);
    #1;
    checkPorts("preload", 16'hFFFF, 16'hFFFF);

    // Assert reset mid-cycle: contents clear before any clock edge.
    #1;
    rst = 1'b1;
    #1;
    checkPorts("async_clear", 16'h0000, 16'h0000);
    @(negedge clk);

    // Write attempted during reset: bypass still shows writeData, storage not.
    applyStimulus(1'b1, 3'd4, 16'h7777, 3'd4, 3'd1);
    #1;
    checkPorts("rst_bypass", 16'h7777, 16'h0000);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 16'h0000, 3'd4, 3'd7);
    #1;
    checkPorts("rst_blocked", 16'h0000, 16'h0000);

    // First edge after reset release performs a write.
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 3'd4, 16'h4444, 3'd0, 3'd1);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 16'h0000, 3'd4, 3'd0);
    #1;
    checkPorts("post_rst_wr", 16'h4444, 16'h0000);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
